serial_reader: RTL
==================

SERIAL_READER -- requirements
Module: serial_reader

Interface
REQ-001 Parameter BAUD_DIV, default 27, clk cycles per 16x-oversample tick (50 MHz / 115200 baud / 16).
REQ-002 Parameter TIMEOUT_TICKS, default 320, maximum oversample ticks allowed between bytes of one packet.
REQ-003 clk  input  1  system clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  serial data in, 8N1, LSB first, idle high.
REQ-006 data_out  output  16  last complete packet payload.
REQ-007 addr  output  2  register address tag of data_out.
REQ-008 dav  output  1  data_out/addr valid, held until acknowledged.
REQ-009 r_ack  input  1  consumer acknowledge of the current word.
REQ-010 frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-011 overrun  output  1  sticky; a completed word was lost while dav was high.

Function
REQ-012 rxd SHALL pass through a two-flop synchronizer before any use.
REQ-013 The tick counter SHALL count 0..BAUD_DIV-1 and pulse tick on wrap; it runs free.
REQ-014 The bit FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE->START on synchronized rxd low; the tick sub-counter is cleared on entry.
REQ-016 START: at tick 8, rxd low -> DATA; rxd high -> IDLE (glitch rejected, no error).
REQ-017 DATA: sample every 16 ticks, bit 0 first; after bit 7 -> STOP.
REQ-018 STOP: at 16 ticks, rxd high -> byte_valid for one cycle; rxd low -> frame_err pulse, byte dropped.
REQ-019 After a frame error the FSM SHALL remain in STOP until rxd is high, then go to IDLE.
REQ-020 The packet FSM SHALL have states P_HDR, P_HI, P_LO.
REQ-021 P_HDR: a byte with [7:2]==6'b101000 latches [1:0] as addr and goes to P_HI; any other byte is discarded.
REQ-022 P_HI: the byte is latched as data[15:8] -> P_LO.
REQ-023 P_LO: the byte is latched as data[7:0]; the word is complete -> P_HDR.
REQ-024 On completion, data_out, addr, and dav=1 SHALL be registered on the cycle after byte_valid.
REQ-025 A frame_err in P_HI or P_LO SHALL return the FSM to P_HDR and discard the partial packet.
REQ-026 In P_HI or P_LO, more than TIMEOUT_TICKS ticks without byte_valid SHALL return the FSM to P_HDR.
REQ-027 dav SHALL clear on the cycle after r_ack is sampled high; r_ack while dav=0 is ignored.
REQ-028 Completion while dav=1 and r_ack=0: the old word is retained, the new word dropped, and overrun is set.
REQ-029 Completion in the same cycle as r_ack: the new word is loaded, dav stays 1, overrun is unchanged.
REQ-030 overrun SHALL clear on r_ack.

Reset
REQ-031 While rst is low: both FSMs idle (IDLE, P_HDR); all counters 0; synchronizer flops 1.
REQ-032 While rst is low: data_out=16'h0000, addr=2'b00, dav=0, frame_err=0, overrun=0.
REQ-033 Reset mid-byte or mid-packet SHALL discard all partial data; the next start bit is decoded normally.

Structure
REQ-034 The header sync pattern 6'b101000, packet state encodings, and BAUD_DIV default SHALL live in the shared serial package used by the writer and write_driver.
REQ-035 The bit-level receiver SHALL be the sub-module serial_rx (rxd in; byte, byte_valid, frame_err out).
REQ-036 Packet assembly and the handshake SHALL reside in serial_reader.

Verification (BAUD_DIV=4)
REQ-037 Bytes A1,12,34 -> one cycle after the third stop bit: dav=1, addr=01, data_out=1234.
REQ-038 Bytes 55,A2,BE,EF -> 55 discarded; addr=10, data_out=BEEF.
REQ-039 A 3-tick low pulse on idle rxd -> no byte, no frame_err, packet FSM stays P_HDR.
REQ-040 A0 then a byte with stop bit low -> one frame_err pulse; then A3,00,FF -> addr=11, data_out=00FF.
REQ-041 Two packets with r_ack held 0 -> first word retained, overrun=1; r_ack -> dav=0, overrun=0.
REQ-042 A0,12, then 400 idle ticks, then 34,56 -> no dav; a subsequent full packet decodes correctly.

Source files
------------

// File: rtl/serial_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_reader_pkg
//  Description : Shared serial-link definitions: bit/packet state encodings,
//                header sync pattern, default baud divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_reader_pkg;

  localparam int          BAUD_DIV_DEFAULT = 27;        // 50 MHz / 115200 / 16
  localparam logic [5:0]  HDR_SYNC         = 6'b101000; // header byte [7:2]

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_HDR = 2'd0,
    P_HI  = 2'd1,
    P_LO  = 2'd2
  } pkt_state_t;

  // A header byte carries the sync pattern in its upper six bits.
  function automatic logic is_header(input logic [7:0] b);
    return (b[7:2] == HDR_SYNC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx
//  Description : 8N1 UART bit receiver with 16x oversampling, start-bit glitch
//                rejection and stop-bit framing check.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_rx
  import serial_reader_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active low
  input  logic       i_rxd,
  output logic       o_tick,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic            r_sync1, r_sync2;
  logic [TW-1:0]   r_div;
  logic            r_tick;
  rx_state_t       r_state, w_state_nxt;
  logic [3:0]      r_sub, w_sub_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_stop_wait, w_stop_wait_nxt;
  logic            r_bv, w_bv_nxt;
  logic            r_fe, w_fe_nxt;
  logic            w_rx;

  assign w_rx         = r_sync2;
  assign o_tick       = r_tick;
  assign o_byte       = r_shift;
  assign o_byte_valid = r_bv;
  assign o_frame_err  = r_fe;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running oversample divider, one-cycle tick on wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == TW'(BAUD_DIV - 1)) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + TW'(1);
      r_tick <= 1'b0;
    end
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_sub       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_stop_wait <= 1'b0;
      r_bv        <= 1'b0;
      r_fe        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sub       <= w_sub_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_stop_wait <= w_stop_wait_nxt;
      r_bv        <= w_bv_nxt;
      r_fe        <= w_fe_nxt;
    end
  end

  // Bit FSM next-state: start check at tick 8, data/stop every 16 ticks.
  always_comb begin
    w_state_nxt     = r_state;
    w_sub_nxt       = r_sub;
    w_bit_nxt       = r_bit;
    w_shift_nxt     = r_shift;
    w_stop_wait_nxt = r_stop_wait;
    w_bv_nxt        = 1'b0;
    w_fe_nxt        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_state_nxt = START;
          w_sub_nxt   = '0;
        end
      end
      START: begin
        if (r_tick) begin
          if (r_sub == 4'd7) begin
            w_sub_nxt   = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rx ? IDLE : DATA;
          end else begin
            w_sub_nxt = r_sub + 4'd1;
          end
        end
      end
      DATA: begin
        if (r_tick) begin
          if (r_sub == 4'd15) begin
            w_sub_nxt   = '0;
            w_shift_nxt = {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) w_state_nxt = STOP;
            else               w_bit_nxt   = r_bit + 3'd1;
          end else begin
            w_sub_nxt = r_sub + 4'd1;
          end
        end
      end
      STOP: begin
        if (r_stop_wait) begin
          // After a framing error, hold until the line returns to idle.
          if (w_rx) begin
            w_stop_wait_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
        end else if (r_tick) begin
          if (r_sub == 4'd15) begin
            w_sub_nxt = '0;
            if (w_rx) begin
              w_bv_nxt    = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_fe_nxt        = 1'b1;
              w_stop_wait_nxt = 1'b1;
            end
          end else begin
            w_sub_nxt = r_sub + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_reader.sv
`default_nettype none
// ============================================================================
//  Module      : serial_reader
//  Description : Receives 3-byte packets (header, data hi, data lo) over a
//                UART link and presents each word with a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_reader
  import serial_reader_pkg::*;
#(
  parameter int BAUD_DIV      = BAUD_DIV_DEFAULT,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  input  logic        rxd,
  input  logic        r_ack,
  output logic [15:0] data_out,
  output logic [1:0]  addr,
  output logic        dav,
  output logic        frame_err,
  output logic        overrun
);

  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);

  logic           w_tick;
  logic [7:0]     w_byte;
  logic           w_byte_valid;
  logic           w_frame_err;
  logic           w_timeout;
  logic           w_complete;
  pkt_state_t     r_pstate, w_pstate_nxt;
  logic [TOW-1:0] r_to;
  logic [1:0]     r_addr_hold;
  logic [7:0]     r_hi;
  logic [15:0]    r_data;
  logic [1:0]     r_addr;
  logic           r_dav;
  logic           r_ovr;

  serial_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_rxd        (rxd),
    .o_tick       (w_tick),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  assign data_out  = r_data;
  assign addr      = r_addr;
  assign dav       = r_dav;
  assign overrun   = r_ovr;
  assign frame_err = w_frame_err;
  assign w_timeout = w_tick && (r_to == TOW'(TIMEOUT_TICKS));

  // Packet FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pstate <= P_HDR;
    else      r_pstate <= w_pstate_nxt;
  end

  // Packet FSM next-state; framing errors and inter-byte timeouts abort.
  always_comb begin
    w_pstate_nxt = r_pstate;
    w_complete   = 1'b0;
    case (r_pstate)
      P_HDR: if (w_byte_valid && is_header(w_byte)) w_pstate_nxt = P_HI;
      P_HI: begin
        if (w_frame_err)       w_pstate_nxt = P_HDR;
        else if (w_byte_valid) w_pstate_nxt = P_LO;
        else if (w_timeout)    w_pstate_nxt = P_HDR;
      end
      P_LO: begin
        if (w_frame_err) begin
          w_pstate_nxt = P_HDR;
        end else if (w_byte_valid) begin
          w_pstate_nxt = P_HDR;
          w_complete   = 1'b1;
        end else if (w_timeout) begin
          w_pstate_nxt = P_HDR;
        end
      end
      default: w_pstate_nxt = P_HDR;
    endcase
  end

  // Inter-byte timeout counter, only running mid-packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_to <= '0;
    else if (r_pstate == P_HDR || w_byte_valid) r_to <= '0;
    else if (w_tick && r_to != TOW'(TIMEOUT_TICKS)) r_to <= r_to + TOW'(1);
  end

  // Capture header address and high data byte while assembling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_hold <= '0;
      r_hi        <= '0;
    end else if (w_byte_valid) begin
      if (r_pstate == P_HDR && is_header(w_byte)) r_addr_hold <= w_byte[1:0];
      if (r_pstate == P_HI)                       r_hi        <= w_byte;
    end
  end

  // Output word, valid/ack handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_addr <= '0;
      r_dav  <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (w_complete) begin
      if (!r_dav || r_ack) begin
        // Simultaneous ack frees the slot: load the new word, overrun kept.
        r_data <= {r_hi, w_byte};
        r_addr <= r_addr_hold;
        r_dav  <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_dav && r_ack) begin
      r_dav <= 1'b0;
      r_ovr <= 1'b0;
    end
  end

endmodule
`default_nettype wire
